// File: rtl/main_controller.sv
// Multicycle RV32I control unit: Moore sequencer, ALU decoder and ImmSrc decoder.
// Optional retired-instruction counter InstrRet is built when CTRL_INSTRET_EN is defined.
module main_controller #(
  parameter bit ILLEGAL_HALT = 1'b1,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic             funct7b5,
  input  logic             Zero,
  input  logic             MemReady,
  output logic             PCWrite,
  output logic             AdrSrc,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             RegWrite,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [2:0]       ALUControl,
  output logic [1:0]       ImmSrc,
  output logic [3:0]       State,
  output logic             Halted
`ifdef CTRL_INSTRET_EN
  ,
  output logic [CNT_W-1:0] InstrRet
`endif
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_JAL      = 4'd8,
    S_ALUWB    = 4'd9,
    S_BEQ      = 4'd10,
    S_HALT     = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  state_t state_q, state_d;

  // Raw Moore decodes before reset gating and the MemReady/Zero qualifiers.
  logic       pc_update;
  logic       branch;
  logic       ir_write_raw;
  logic       reg_write_raw;
  logic       mem_write_raw;
  logic [1:0] alu_op;

  function automatic logic [2:0] alu_decode(
    input logic [1:0] aluop,
    input logic [2:0] f3,
    input logic       op5,
    input logic       f7b5
  );
    logic [2:0] r;
    r = ALU_ADD;
    case (aluop)
      2'b00: r = ALU_ADD;
      2'b01: r = ALU_SUB;
      2'b10: begin
        case (f3)
          3'b000:  r = (op5 & f7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  r = ALU_SLT;
          3'b110:  r = ALU_OR;
          3'b111:  r = ALU_AND;
          default: r = ALU_ADD;
        endcase
      end
      default: r = ALU_ADD;
    endcase
    return r;
  endfunction

  function automatic logic [1:0] imm_decode(input logic [6:0] opc);
    logic [1:0] r;
    case (opc)
      OP_SW:   r = 2'b01;
      OP_BEQ:  r = 2'b10;
      OP_JAL:  r = 2'b11;
      default: r = 2'b00;
    endcase
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    state_d = MemReady ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECR;
          OP_ITYPE:     state_d = S_EXECI;
          OP_JAL:       state_d = S_JAL;
          OP_BEQ:       state_d = S_BEQ;
          default:      state_d = ILLEGAL_HALT ? S_HALT : S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_d = MemReady ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = MemReady ? S_FETCH : S_MEMWRITE;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_JAL:      state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
      S_HALT:     state_d = S_HALT;
      default:    state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    pc_update     = 1'b0;
    branch        = 1'b0;
    ir_write_raw  = 1'b0;
    reg_write_raw = 1'b0;
    mem_write_raw = 1'b0;
    alu_op        = 2'b00;
    AdrSrc        = 1'b0;
    ResultSrc     = 2'b00;
    ALUSrcA       = 2'b00;
    ALUSrcB       = 2'b00;
    case (state_q)
      S_FETCH: begin
        ALUSrcB      = 2'b10;
        ResultSrc    = 2'b10;
        ir_write_raw = MemReady;
        pc_update    = MemReady;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc     = 2'b01;
        reg_write_raw = 1'b1;
      end
      // Strobe is held through the wait so the memory sees a stable request.
      S_MEMWRITE: begin
        AdrSrc        = 1'b1;
        mem_write_raw = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA = 2'b10;
        alu_op  = 2'b10;
      end
      S_EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        alu_op  = 2'b10;
      end
      S_JAL: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        pc_update = 1'b1;
      end
      S_ALUWB: begin
        reg_write_raw = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA = 2'b10;
        alu_op  = 2'b01;
        branch  = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Enables are masked by reset so an in-flight access is dropped the instant reset falls.
  assign PCWrite    = reset & (pc_update | (branch & Zero));
  assign IRWrite    = reset & ir_write_raw;
  assign RegWrite   = reset & reg_write_raw;
  assign MemWrite   = reset & mem_write_raw;
  assign ALUControl = alu_decode(alu_op, funct3, op[5], funct7b5);
  assign ImmSrc     = imm_decode(op);
  assign State      = state_q;
  assign Halted     = (state_q == S_HALT);

`ifdef CTRL_INSTRET_EN
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             retire;

  // Illegal-op NOPs leave from DECODE, so they never reach these states.
  always_comb begin
    retire = 1'b0;
    case (state_q)
      S_MEMWB, S_ALUWB, S_BEQ: retire = 1'b1;
      S_MEMWRITE:              retire = MemReady;
      default:                 retire = 1'b0;
    endcase
    instret_d = instret_q + {{(CNT_W-1){1'b0}}, retire};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instret_q <= '0;
    end else begin
      instret_q <= instret_d;
    end
  end

  assign InstrRet = instret_q;
`else
  localparam int cnt_w_unused = CNT_W;
`endif

endmodule

// File: tb/tb_main_controller.sv
// Directed bench for main_controller: per-cycle vector table plus reset and retire-count sequences.
module tb_main_controller;

  logic       clk;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       MemReady;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic [3:0] State;
  logic       Halted;
`ifdef CTRL_INSTRET_EN
  logic [31:0] InstrRet;
`endif

  main_controller dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .Zero       (Zero),
    .MemReady   (MemReady),
    .PCWrite    (PCWrite),
    .AdrSrc     (AdrSrc),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .RegWrite   (RegWrite),
    .ResultSrc  (ResultSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ALUControl (ALUControl),
    .ImmSrc     (ImmSrc),
    .State      (State),
    .Halted     (Halted)
`ifdef CTRL_INSTRET_EN
    ,
    .InstrRet   (InstrRet)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc}
  logic [15:0] ctl;
  assign ctl = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
                ALUSrcA, ALUSrcB, ALUControl, ImmSrc};

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic        z;
    logic        mr;
    logic [3:0]  st;
    logic [15:0] ctl;
    logic        hlt;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic v(input logic [6:0] o, input logic [2:0] f, input logic f7, input logic z,
                   input logic mr, input logic [3:0] st, input logic pcw, input logic adr,
                   input logic mw, input logic irw, input logic rw, input logic [1:0] rs,
                   input logic [1:0] sa, input logic [1:0] sb, input logic [2:0] alc,
                   input logic [1:0] imm, input logic h);
    vec_t t;
    t.op = o; t.f3 = f; t.f7 = f7; t.z = z; t.mr = mr; t.st = st;
    t.ctl = {pcw, adr, mw, irw, rw, rs, sa, sb, alc, imm};
    t.hlt = h;
    vecs.push_back(t);
  endtask

  // FETCH with MemReady=1 and DECODE rows recur in every instruction.
  task automatic vf(input logic [6:0] o, input logic [2:0] f, input logic f7, input logic z,
                    input logic [1:0] imm);
    v(o, f, f7, z, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 2'b00, 2'b10, 3'b000, imm, 1'b0);
    v(o, f, f7, z, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 3'b000, imm, 1'b0);
  endtask

  logic mon_en = 1'b0;
  int   rw_seen = 0;
  always @(negedge clk) if (mon_en && RegWrite) rw_seen++;

  task automatic set_in(input logic [6:0] o, input logic [2:0] f, input logic f7,
                        input logic z, input logic mr);
    op = o; funct3 = f; funct7b5 = f7; Zero = z; MemReady = mr;
  endtask

  initial begin
    // add, then sub (f7b5=1)
    vf(7'h33, 3'd0, 1'b0, 1'b0, 2'b00);
    v(7'h33, 3'd0, 1'b0, 1'b0, 1'b1, 4'd6, 1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00,2'b10,2'b00,3'b000,2'b00,1'b0);
    v(7'h33, 3'd0, 1'b0, 1'b0, 1'b1, 4'd9, 1'b0,1'b0,1'b0,1'b0,1'b1, 2'b00,2'b00,2'b00,3'b000,2'b00,1'b0);
    vf(7'h33, 3'd0, 1'b1, 1'b0, 2'b00);
    v(7'h33, 3'd0, 1'b1, 1'b0, 1'b1, 4'd6, 1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00,2'b10,2'b00,3'b001,2'b00,1'b0);
    v(7'h33, 3'd0, 1'b1, 1'b0, 1'b1, 4'd9, 1'b0,1'b0,1'b0,1'b0,1'b1, 2'b00,2'b00,2'b00,3'b000,2'b00,1'b0);
    // lw: one FETCH stall, two MEMREAD stalls
    v(7'h03, 3'd2, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0,1'b0,1'b0,1'b0,1'b0, 2'b10,2'b00,2'b10,3'b000,2'b00,1'b0);
    vf(7'h03, 3'd2, 1'b0, 1'b0, 2'b00);
    v(7'h03, 3'd2, 1'b0, 1'b0, 1'b1, 4'd2, 1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00,2'b10,2'b01,3'b000,2'b00,1'b0);
    v(7'h03, 3'd2, 1'b0, 1'b0, 1'b0, 4'd3, 1'b0,1'b1,1'b0,1'b0,1'b0, 2'b00,2'b00,2'b00,3'b000,2'b00,1'b0);
    v(7'h03, 3'd2, 1'b0, 1'b0, 1'b0, 4'd3, 1'b0,1'b1,1'b0,1'b0,1'b0, 2'b00,2'b00,2'b00,3'b000,2'b00,1'b0);
    v(7'h03, 3'd2, 1'b0, 1'b0, 1'b1, 4'd3, 1'b0,1'b1,1'b0,1'b0,1'b0, 2'b00,2'b00,2'b00,3'b000,2'b00,1'b0);
    v(7'h03, 3'd2, 1'b0, 1'b0, 1'b1, 4'd4, 1'b0,1'b0,1'b0,1'b0,1'b1, 2'b01,2'b00,2'b00,3'b000,2'b00,1'b0);
    // sw: MemWrite held across one stall cycle
    vf(7'h23, 3'd2, 1'b0, 1'b0, 2'b01);
    v(7'h23, 3'd2, 1'b0, 1'b0, 1'b1, 4'd2, 1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00,2'b10,2'b01,3'b000,2'b01,1'b0);
    v(7'h23, 3'd2, 1'b0, 1'b0, 1'b0, 4'd5, 1'b0,1'b1,1'b1,1'b0,1'b0, 2'b00,2'b00,2'b00,3'b000,2'b01,1'b0);
    v(7'h23, 3'd2, 1'b0, 1'b0, 1'b1, 4'd5, 1'b0,1'b1,1'b1,1'b0,1'b0, 2'b00,2'b00,2'b00,3'b000,2'b01,1'b0);
    // beq taken, then not taken
    vf(7'h63, 3'd0, 1'b0, 1'b1, 2'b10);
    v(7'h63, 3'd0, 1'b0, 1'b1, 1'b1, 4'd10, 1'b1,1'b0,1'b0,1'b0,1'b0, 2'b00,2'b10,2'b00,3'b001,2'b10,1'b0);
    vf(7'h63, 3'd0, 1'b0, 1'b0, 2'b10);
    v(7'h63, 3'd0, 1'b0, 1'b0, 1'b1, 4'd10, 1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00,2'b10,2'b00,3'b001,2'b10,1'b0);
    // jal
    vf(7'h6F, 3'd0, 1'b0, 1'b0, 2'b11);
    v(7'h6F, 3'd0, 1'b0, 1'b0, 1'b1, 4'd8, 1'b1,1'b0,1'b0,1'b0,1'b0, 2'b00,2'b01,2'b10,3'b000,2'b11,1'b0);
    v(7'h6F, 3'd0, 1'b0, 1'b0, 1'b1, 4'd9, 1'b0,1'b0,1'b0,1'b0,1'b1, 2'b00,2'b00,2'b00,3'b000,2'b11,1'b0);
    // ori, slti, andi, addi with f7b5=1 (op[5]=0 keeps add)
    vf(7'h13, 3'd6, 1'b0, 1'b0, 2'b00);
    v(7'h13, 3'd6, 1'b0, 1'b0, 1'b1, 4'd7, 1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00,2'b10,2'b01,3'b011,2'b00,1'b0);
    v(7'h13, 3'd6, 1'b0, 1'b0, 1'b1, 4'd9, 1'b0,1'b0,1'b0,1'b0,1'b1, 2'b00,2'b00,2'b00,3'b000,2'b00,1'b0);
    vf(7'h13, 3'd2, 1'b0, 1'b0, 2'b00);
    v(7'h13, 3'd2, 1'b0, 1'b0, 1'b1, 4'd7, 1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00,2'b10,2'b01,3'b101,2'b00,1'b0);
    v(7'h13, 3'd2, 1'b0, 1'b0, 1'b1, 4'd9, 1'b0,1'b0,1'b0,1'b0,1'b1, 2'b00,2'b00,2'b00,3'b000,2'b00,1'b0);
    vf(7'h13, 3'd7, 1'b0, 1'b0, 2'b00);
    v(7'h13, 3'd7, 1'b0, 1'b0, 1'b1, 4'd7, 1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00,2'b10,2'b01,3'b010,2'b00,1'b0);
    v(7'h13, 3'd7, 1'b0, 1'b0, 1'b1, 4'd9, 1'b0,1'b0,1'b0,1'b0,1'b1, 2'b00,2'b00,2'b00,3'b000,2'b00,1'b0);
    vf(7'h13, 3'd0, 1'b1, 1'b0, 2'b00);
    v(7'h13, 3'd0, 1'b1, 1'b0, 1'b1, 4'd7, 1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00,2'b10,2'b01,3'b000,2'b00,1'b0);
    v(7'h13, 3'd0, 1'b1, 1'b0, 1'b1, 4'd9, 1'b0,1'b0,1'b0,1'b0,1'b1, 2'b00,2'b00,2'b00,3'b000,2'b00,1'b0);
    // illegal opcode -> sticky HALT
    vf(7'h7F, 3'd0, 1'b0, 1'b0, 2'b00);
    v(7'h7F, 3'd0, 1'b0, 1'b0, 1'b1, 4'd11, 1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00,2'b00,2'b00,3'b000,2'b00,1'b1);
    v(7'h7F, 3'd0, 1'b0, 1'b1, 1'b1, 4'd11, 1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00,2'b00,2'b00,3'b000,2'b00,1'b1);

    // Reset held 3 clocks with MemReady=1
    set_in(7'h33, 3'd0, 1'b0, 1'b0, 1'b1);
    reset = 1'b1;
    #2 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst State", 32'(State), 32'd0);
    chk("rst enables", {28'd0, PCWrite, IRWrite, RegWrite, MemWrite}, 32'd0);
    chk("rst Halted", 32'(Halted), 32'd0);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      set_in(vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].z, vecs[i].mr);
      #1;
      chk($sformatf("row%0d State", i), 32'(State), 32'(vecs[i].st));
      chk($sformatf("row%0d ctl", i), 32'(ctl), 32'(vecs[i].ctl));
      chk($sformatf("row%0d Halted", i), 32'(Halted), 32'(vecs[i].hlt));
      @(posedge clk);
      #1;
    end

    // Reset leaves HALT asynchronously
    chk("halt sticky", 32'(State), 32'd11);
    #2 reset = 1'b0;
    #1;
    chk("halt exit State", 32'(State), 32'd0);
    chk("halt exit Halted", 32'(Halted), 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;

    // Reset asserted mid-EXECR aborts the add before writeback
    set_in(7'h33, 3'd0, 1'b0, 1'b0, 1'b1);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    chk("mid EXECR State", 32'(State), 32'd6);
    mon_en = 1'b1;
    #2 reset = 1'b0;
    #1;
    chk("mid rst State", 32'(State), 32'd0);
    chk("mid rst RegWrite", 32'(RegWrite), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    mon_en = 1'b0;
    chk("aborted RegWrite cycles", 32'(rw_seen), 32'd0);
    chk("restart State", 32'(State), 32'd6);

    // Finish the add, then lw and beq back to back with MemReady tied high
    repeat (2) @(posedge clk);
    #1;
    chk("add done State", 32'(State), 32'd0);
    set_in(7'h03, 3'd2, 1'b0, 1'b0, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    chk("lw done State", 32'(State), 32'd0);
    set_in(7'h63, 3'd0, 1'b0, 1'b1, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("beq done State", 32'(State), 32'd0);
`ifdef CTRL_INSTRET_EN
    chk("InstrRet", InstrRet, 32'd3);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
